// File: rtl/icache_pkg.sv
// Shared types and line-geometry constants for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINE_BYTES     = 16;
  localparam int OFFSET_BITS    = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_WIDTH     = 32;

  typedef enum logic {
    ST_IDLE,
    ST_REFILL
  } state_e;

endpackage : icache_pkg

// File: rtl/icache_array.sv
// Line storage for the instruction cache: valid bits, tags and line data with a
// combinational read port, a single write port and a clear-all for invalidation.
module icache_array
  import icache_pkg::*;
#(
  parameter int NLINES     = 64,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 22,
  parameter int LINE_W     = 128
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]     rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [LINE_W-1:0]     wr_data_i,
  input  logic                  wr_valid_i,
  input  logic                  clear_all_i
);

  logic [NLINES-1:0]   valid_q;
  logic [TAG_BITS-1:0] tag_q  [NLINES];
  logic [LINE_W-1:0]   data_q [NLINES];

  // Clear-all takes priority; a fill landing on the same edge is written invalid anyway.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; valid_q alone gates their use,
  // and leaving them reset-free lets them map onto plain storage.
  always_ff @(posedge clock) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule : icache_array

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path to ifetch and a
// four-beat refill engine toward the memory arbiter.
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int NLINES     = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic                  cache_rd,
  output logic [DATA_WIDTH-1:0] cache_data,
  output logic                  cache_waitrequest,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [31:0]           mem_rddata,
  input  logic                  mem_waitrequest,
  input  logic                  inv_all
);

  localparam int INDEX_BITS = $clog2(NLINES);
  localparam int BASE_BITS  = ADDR_WIDTH - OFFSET_BITS;
  localparam int TAG_BITS   = BASE_BITS - INDEX_BITS;

  state_e                  state_q, state_d;
  logic [1:0]              beat_q, beat_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [BASE_BITS-1:0]    miss_addr_q, miss_addr_d;
  logic                    inv_pend_q, inv_pend_d;
  logic [WORD_WIDTH-1:0]   fill_q [WORDS_PER_LINE-1];
  logic [WORD_WIDTH-1:0]   fill_d [WORDS_PER_LINE-1];

  logic [BASE_BITS-1:0]    line_base;
  logic [INDEX_BITS-1:0]   lookup_idx;
  logic [TAG_BITS-1:0]     lookup_tag;
  logic                    rd_valid;
  logic [TAG_BITS-1:0]     rd_tag;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    hit;
  logic                    beat_accept;
  logic                    arr_we;
  logic                    arr_wr_valid;
  logic [DATA_WIDTH-1:0]   arr_wr_data;
  logic                    unused_offset_bits;

  assign line_base          = cache_addr[ADDR_WIDTH-1:OFFSET_BITS];
  assign lookup_idx         = line_base[INDEX_BITS-1:0];
  assign lookup_tag         = line_base[BASE_BITS-1:INDEX_BITS];
  assign unused_offset_bits = ^cache_addr[OFFSET_BITS-1:0];

  icache_array #(
    .NLINES     (NLINES),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .LINE_W     (DATA_WIDTH)
  ) u_array (
    .clock       (clock),
    .reset_n     (reset_n),
    .rd_idx_i    (lookup_idx),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .we_i        (arr_we),
    .wr_idx_i    (miss_addr_q[INDEX_BITS-1:0]),
    .wr_tag_i    (miss_addr_q[BASE_BITS-1:INDEX_BITS]),
    .wr_data_i   (arr_wr_data),
    .wr_valid_i  (arr_wr_valid),
    .clear_all_i (inv_all)
  );

  assign hit               = rd_valid && (rd_tag == lookup_tag);
  assign cache_waitrequest = cache_rd && ((state_q != ST_IDLE) || !hit);
  assign cache_data        = cache_waitrequest ? '0 : rd_data;

  assign beat_accept  = mem_rd_q && !mem_waitrequest;
  // The last beat bypasses the fill buffer so the line is written on its accept edge.
  assign arr_wr_data  = {fill_q[0], fill_q[1], fill_q[2], mem_rddata};
  // An invalidate seen at any point of the refill, including its final edge, leaves the line invalid.
  assign arr_wr_valid = !(inv_pend_q || inv_all);

  // NOTE: every next-state signal gets its default first, so no path can hold a value
  // and infer a latch; the comb block uses blocking '=' only.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    miss_addr_d = miss_addr_q;
    inv_pend_d  = inv_pend_q;
    fill_d      = fill_q;
    arr_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cache_rd && !hit) begin
          miss_addr_d = line_base;
          beat_d      = 2'd0;
          mem_rd_d    = 1'b1;
          mem_addr_d  = {line_base, {OFFSET_BITS{1'b0}}};
          state_d     = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (inv_all) begin
          inv_pend_d = 1'b1;
        end
        if (beat_accept) begin
          if (beat_q == 2'd3) begin
            arr_we     = 1'b1;
            mem_rd_d   = 1'b0;
            inv_pend_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            for (int w = 0; w < WORDS_PER_LINE - 1; w++) begin
              if (beat_q == 2'(w)) begin
                fill_d[w] = mem_rddata;
              end
            end
            beat_d     = beat_q + 2'd1;
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(WORD_WIDTH / 8);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= 2'd0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      miss_addr_q <= '0;
      inv_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      miss_addr_q <= miss_addr_d;
      inv_pend_q  <= inv_pend_d;
    end
  end

  always_ff @(posedge clock) begin
    fill_q <= fill_d;
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

endmodule : icache

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against a line-level cache/memory model.
module tb_icache;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int NL = 64;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] cache_addr = '0;
  logic          cache_rd = 1'b0;
  logic [DW-1:0] cache_data;
  logic          cache_waitrequest;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [31:0]   mem_rddata = '0;
  logic          mem_waitrequest = 1'b0;
  logic          inv_all = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_valid [NL];
  logic [21:0] m_tag   [NL];

  always #5 clock = ~clock;

  icache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NLINES(NL)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .cache_addr        (cache_addr),
    .cache_rd          (cache_rd),
    .cache_data        (cache_data),
    .cache_waitrequest (cache_waitrequest),
    .mem_addr          (mem_addr),
    .mem_rd            (mem_rd),
    .mem_rddata        (mem_rddata),
    .mem_waitrequest   (mem_waitrequest),
    .inv_all           (inv_all)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [127:0] golden_line(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'b0000};
    return {mem_word(b), mem_word(b + 32'd4), mem_word(b + 32'd8), mem_word(b + 32'd12)};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[9:4]] && (m_tag[a[9:4]] == a[31:10]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch from the requester's view; the bench plays memory, optionally stalling
  // or pulsing inv_all during a chosen beat. Entered and left at negedge+1.
  task automatic fetch(input logic [31:0] addr, input int stall_beat, input int stall_n,
                       input int inv_beat, input bit rnd);
    bit          exp_hit, inv_seen, done, stall;
    logic [31:0] base;
    int          beat, stalls, waits;
    exp_hit  = model_hit(addr);
    base     = {addr[31:4], 4'b0000};
    beat     = 0;
    stalls   = 0;
    waits    = 0;
    inv_seen = 1'b0;
    done     = 1'b0;
    cache_addr = addr;
    cache_rd   = 1'b1;
    #1;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      if (!cache_waitrequest) begin
        check("line_data", cache_data, golden_line(addr));
        done = 1'b1;
      end else begin
        waits++;
        check("data_zero_when_wait", cache_data, '0);
        if (cyc == 0) check("no_mem_rd_in_idle", mem_rd, 1'b0);
        else          check("mem_rd_in_refill", mem_rd, 1'b1);
        if (mem_rd) begin
          check("mem_addr", mem_addr, base + 32'(4 * beat));
          if (rnd) stall = ($urandom_range(0, 2) == 0) && (stalls < 8);
          else     stall = (beat == stall_beat) && (stalls < stall_n);
          mem_waitrequest = stall;
          mem_rddata      = mem_word(mem_addr);
          if (beat == inv_beat && !inv_seen) begin
            inv_all  = 1'b1;
            inv_seen = 1'b1;
          end
          if (stall) stalls++;
          else       beat++;
        end
        @(negedge clock);
        inv_all         = 1'b0;
        mem_waitrequest = 1'b0;
        mem_rddata      = '0;
        #1;
        if (beat == 4 && inv_seen) done = 1'b1;
      end
    end
    check("fetch_completed", done, 1'b1);
    check("wait_cycles", waits, exp_hit ? 0 : 5 + stalls);
    if (inv_seen) begin
      model_clear();
    end else if (!exp_hit) begin
      m_valid[addr[9:4]] = 1'b1;
      m_tag[addr[9:4]]   = addr[31:10];
    end
    cache_rd = 1'b0;
    @(negedge clock);
    #1;
    check("idle_no_wait", cache_waitrequest, 1'b0);
    check("idle_mem_rd", mem_rd, 1'b0);
  endtask

  // inv_all in IDLE: the same-cycle lookup still sees the old contents.
  task automatic inv_on_hit(input logic [31:0] addr);
    cache_addr = addr;
    cache_rd   = 1'b1;
    inv_all    = 1'b1;
    #1;
    check("inv_same_cycle_wait", cache_waitrequest, !model_hit(addr));
    check("inv_same_cycle_data", cache_data, golden_line(addr));
    @(negedge clock);
    inv_all  = 1'b0;
    model_clear();
    #1;
    check("inv_next_cycle_miss", cache_waitrequest, 1'b1);
    cache_rd = 1'b0;
    @(negedge clock);
    #1;
  endtask

  task automatic reset_mid_refill(input logic [31:0] addr);
    cache_addr      = addr;
    cache_rd        = 1'b1;
    mem_waitrequest = 1'b0;
    repeat (3) begin
      mem_rddata = mem_word(mem_addr);
      @(negedge clock);
      #1;
    end
    check("rst_beat2_addr", mem_addr, addr + 32'd8);
    reset_n = 1'b0;
    #1;
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    cache_rd = 1'b0;
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int          inv_b;
    model_clear();
    #1;
    check("reset_mem_rd", mem_rd, 1'b0);
    check("reset_mem_addr", mem_addr, '0);
    check("reset_wait_idle", cache_waitrequest, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;

    fetch(32'h0000_0040, -1, 0, -1, 1'b0);   // cold miss, 5 wait cycles
    fetch(32'h0000_0044, -1, 0, -1, 1'b0);   // hit same cycle
    fetch(32'h0000_0440, -1, 0, -1, 1'b0);   // conflict miss evicts 0x40
    fetch(32'h0000_0040, -1, 0, -1, 1'b0);   // misses again
    fetch(32'h0000_0440, -1, 0, -1, 1'b0);
    fetch(32'h0000_0040,  2, 3, -1, 1'b0);   // 3-cycle stall on beat 2 -> 8 wait cycles
    fetch(32'h0000_0080, -1, 0,  1, 1'b0);   // inv during beat 1
    fetch(32'h0000_0080, -1, 0, -1, 1'b0);   // line left invalid -> miss
    fetch(32'h0000_00C0, -1, 0,  3, 1'b0);   // inv on final beat wins
    fetch(32'h0000_00C0, -1, 0, -1, 1'b0);
    inv_on_hit(32'h0000_00C8);
    fetch(32'h0000_00C0, -1, 0, -1, 1'b0);
    fetch(32'h0000_0040, -1, 0, -1, 1'b0);
    fetch(32'h0000_004C, -1, 0, -1, 1'b0);
    reset_mid_refill(32'h0000_0100);
    fetch(32'h0000_0040, -1, 0, -1, 1'b0);   // prior hit now misses

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        cache_rd = 1'b0;
        inv_all  = 1'b1;
        #1;
        check("rand_idle_inv_wait", cache_waitrequest, 1'b0);
        @(negedge clock);
        inv_all = 1'b0;
        model_clear();
        #1;
      end else begin
        a = {$urandom_range(0, 3) == 3 ? 22'h2A_5A5A : 22'($urandom_range(0, 2)),
             6'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
        inv_b = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
        fetch(a, -1, 0, inv_b, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule : tb_icache
